// File: rtl/irq_controller_pkg.sv
// -----------------------------------------------------------------------------
// irq_controller_pkg
// Shared definitions for the interrupt controller slice:
//   - source count and index width
//   - source index constants (timer, uart_rx, uart_tx, external)
//   - FSM state encoding
//   - irq_onehot(): index -> one-hot source mask helper
// -----------------------------------------------------------------------------
package irq_controller_pkg;

  localparam int IRQ_NUM_SRC = 4;
  localparam int IRQ_IDX_W   = 2;

  localparam logic [IRQ_IDX_W-1:0] IRQ_SRC_TIMER   = 2'd0;
  localparam logic [IRQ_IDX_W-1:0] IRQ_SRC_UART_RX = 2'd1;
  localparam logic [IRQ_IDX_W-1:0] IRQ_SRC_UART_TX = 2'd2;
  localparam logic [IRQ_IDX_W-1:0] IRQ_SRC_EXT     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // Decode a source index into a one-hot mask over the sources.
  function automatic logic [IRQ_NUM_SRC-1:0] irq_onehot(input logic [IRQ_IDX_W-1:0] idx);
    logic [IRQ_NUM_SRC-1:0] mask;
    case (idx)
      IRQ_SRC_TIMER:   mask = 4'b0001;
      IRQ_SRC_UART_RX: mask = 4'b0010;
      IRQ_SRC_UART_TX: mask = 4'b0100;
      IRQ_SRC_EXT:     mask = 4'b1000;
      default:         mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// -----------------------------------------------------------------------------
// irq_controller_if
// Bundles the peripheral/pipeline side signals of the interrupt controller.
//   src_req[3:0]     peripheral requests (bit0 timer .. bit3 external)
//   irq_mask[3:0]    per-source enable
//   pc_high          PC[31] of decode instruction (1 = kernel, blocks irq)
//   irq_ack          pulse when the interrupt redirect is taken
//   irq_done         pulse when the handler returns to user mode
//   irq              request to control unit
//   irq_cause[1:0]   index of source requested / serviced
//   irq_pending[3:0] pending-source register
//   irq_active       handler in service
// Modports: slave = controller, master = pipeline / peripherals.
// -----------------------------------------------------------------------------
interface irq_controller_if;
  import irq_controller_pkg::*;

  logic [IRQ_NUM_SRC-1:0] src_req;
  logic [IRQ_NUM_SRC-1:0] irq_mask;
  logic                   pc_high;
  logic                   irq_ack;
  logic                   irq_done;
  logic                   irq;
  logic [IRQ_IDX_W-1:0]   irq_cause;
  logic [IRQ_NUM_SRC-1:0] irq_pending;
  logic                   irq_active;

  modport slave (
    input  src_req, irq_mask, pc_high, irq_ack, irq_done,
    output irq, irq_cause, irq_pending, irq_active
  );

  modport master (
    output src_req, irq_mask, pc_high, irq_ack, irq_done,
    input  irq, irq_cause, irq_pending, irq_active
  );

endinterface

// File: rtl/irq_controller_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Fixed-priority encoder, bit0 highest priority.
//   req[3:0]  candidate sources
//   valid     any bit of req set
//   idx[1:0]  lowest set index (0 when none set)
// -----------------------------------------------------------------------------
module irq_prio_enc
  import irq_controller_pkg::*;
(
  input  logic [IRQ_NUM_SRC-1:0] req,
  output logic                   valid,
  output logic [IRQ_IDX_W-1:0]   idx
);

  // Lowest set bit wins.
  always_comb begin
    valid = 1'b1;
    idx   = IRQ_SRC_TIMER;
    casez (req)
      4'b???1: idx = IRQ_SRC_TIMER;
      4'b??10: idx = IRQ_SRC_UART_RX;
      4'b?100: idx = IRQ_SRC_UART_TX;
      4'b1000: idx = IRQ_SRC_EXT;
      default: begin
        valid = 1'b0;
        idx   = IRQ_SRC_TIMER;
      end
    endcase
  end

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// Collects peripheral interrupt requests into a pending register, selects the
// highest-priority enabled source and runs a IDLE -> REQ -> SERVICE handshake
// with the pipeline. Nesting is not allowed: new sources only pend while a
// handler is in service.
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous, active-high
//   bus    irq_controller_if.slave (requests, mask, pc_high, ack/done, outputs)
// Build option:
//   IRQ_EDGE_EN  defined   -> pending sets only on a 0->1 edge of src_req[i]
//                undefined -> level mode, pending sets whenever src_req[i] is 1
// -----------------------------------------------------------------------------
module irq_controller
  import irq_controller_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  irq_controller_if.slave bus
);

  irq_state_e             state_r;
  logic                   irq_r;
  logic                   irq_active_r;
  logic [IRQ_IDX_W-1:0]   cause_r;
  logic [IRQ_NUM_SRC-1:0] pending_r;

  logic [IRQ_NUM_SRC-1:0] set_s;
  logic [IRQ_NUM_SRC-1:0] clr_s;
  logic [IRQ_NUM_SRC-1:0] eligible_s;
  logic                   enc_valid_s;
  logic [IRQ_IDX_W-1:0]   enc_idx_s;

`ifdef IRQ_EDGE_EN
  logic [IRQ_NUM_SRC-1:0] src_prev_r;

  // Previous src_req sample for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_prev_r <= 4'b0000;
    end else begin
      src_prev_r <= bus.src_req;
    end
  end

  assign set_s = bus.src_req & ~src_prev_r;
`else
  assign set_s = bus.src_req;
`endif

  // Acknowledge clears the bit of the cause being serviced; only valid in REQ.
  always_comb begin
    clr_s = 4'b0000;
    if ((state_r == ST_REQ) && bus.irq_ack) begin
      clr_s = irq_onehot(cause_r);
    end else begin
      clr_s = 4'b0000;
    end
  end

  // Pending register: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= 4'b0000;
    end else begin
      pending_r <= (pending_r & ~clr_s) | set_s;
    end
  end

  assign eligible_s = pending_r & bus.irq_mask;

  irq_prio_enc u_prio_enc (
    .req   (eligible_s),
    .valid (enc_valid_s),
    .idx   (enc_idx_s)
  );

  // Handshake FSM with registered irq / irq_active / irq_cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      irq_r        <= 1'b0;
      irq_active_r <= 1'b0;
      cause_r      <= IRQ_SRC_TIMER;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enc_valid_s && !bus.pc_high) begin
            state_r      <= ST_REQ;
            irq_r        <= 1'b1;
            irq_active_r <= 1'b0;
            cause_r      <= enc_idx_s;
          end else begin
            state_r      <= ST_IDLE;
            irq_r        <= 1'b0;
            irq_active_r <= 1'b0;
          end
        end
        ST_REQ: begin
          // Ack beats withdrawal; a mask change does not withdraw.
          if (bus.irq_ack) begin
            state_r      <= ST_SERVICE;
            irq_r        <= 1'b0;
            irq_active_r <= 1'b1;
          end else if (bus.pc_high) begin
            state_r      <= ST_IDLE;
            irq_r        <= 1'b0;
            irq_active_r <= 1'b0;
          end else begin
            state_r      <= ST_REQ;
            irq_r        <= 1'b1;
            irq_active_r <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (bus.irq_done) begin
            state_r      <= ST_IDLE;
            irq_r        <= 1'b0;
            irq_active_r <= 1'b0;
          end else begin
            state_r      <= ST_SERVICE;
            irq_r        <= 1'b0;
            irq_active_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          irq_r        <= 1'b0;
          irq_active_r <= 1'b0;
          cause_r      <= IRQ_SRC_TIMER;
        end
      endcase
    end
  end

  assign bus.irq         = irq_r;
  assign bus.irq_active  = irq_active_r;
  assign bus.irq_cause   = cause_r;
  assign bus.irq_pending = pending_r;

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
// Directed-vector bench for irq_controller. Inputs change 1 time unit after a
// rising edge and outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_irq_controller;
  import irq_controller_pkg::*;

  logic clk;
  logic reset;
  int   checks_cnt;
  int   errors_cnt;

  irq_controller_if bus ();

  irq_controller u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic irq_e, input logic act_e,
                            input logic [1:0] cause_e, input logic [3:0] pend_e);
    check_val({tag, ".irq"},     {7'd0, bus.irq},        {7'd0, irq_e});
    check_val({tag, ".active"},  {7'd0, bus.irq_active}, {7'd0, act_e});
    check_val({tag, ".cause"},   {6'd0, bus.irq_cause},  {6'd0, cause_e});
    check_val({tag, ".pending"}, {4'd0, bus.irq_pending},{4'd0, pend_e});
  endtask

  task automatic pulse_ack();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    bus.irq_done = 1'b1;
    tick();
    bus.irq_done = 1'b0;
  endtask

  initial begin
    checks_cnt   = 0;
    errors_cnt   = 0;
    reset        = 1'b1;
    bus.src_req  = 4'b0000;
    bus.irq_mask = 4'b1111;
    bus.pc_high  = 1'b0;
    bus.irq_ack  = 1'b0;
    bus.irq_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_outs("reset", 1'b0, 1'b0, 2'd0, 4'b0000);

    // Single timer request: pending after 1st edge, irq after 2nd.
    bus.src_req = 4'b0001;
    tick();
    bus.src_req = 4'b0000;
    check_outs("t1_edge1", 1'b0, 1'b0, 2'd0, 4'b0001);
    tick();
    check_outs("t1_req", 1'b1, 1'b0, IRQ_SRC_TIMER, 4'b0001);
    pulse_ack();
    check_outs("t1_svc", 1'b0, 1'b1, 2'd0, 4'b0000);
    // Ack outside REQ is ignored.
    pulse_ack();
    check_outs("t1_ack_in_svc", 1'b0, 1'b1, 2'd0, 4'b0000);
    pulse_done();
    check_outs("t1_idle", 1'b0, 1'b0, 2'd0, 4'b0000);
    // Done outside SERVICE is ignored.
    pulse_done();
    check_outs("t1_done_idle", 1'b0, 1'b0, 2'd0, 4'b0000);

    // Two sources together: uart_rx first, then external.
    bus.src_req = 4'b1010;
    tick();
    bus.src_req = 4'b0000;
    tick();
    check_outs("t2_req1", 1'b1, 1'b0, IRQ_SRC_UART_RX, 4'b1010);
    pulse_ack();
    check_outs("t2_svc1", 1'b0, 1'b1, 2'd1, 4'b1000);
    pulse_done();
    check_outs("t2_idle", 1'b0, 1'b0, 2'd1, 4'b1000);
    tick();
    check_outs("t2_req2", 1'b1, 1'b0, IRQ_SRC_EXT, 4'b1000);
    pulse_ack();
    pulse_done();
    check_outs("t2_end", 1'b0, 1'b0, 2'd3, 4'b0000);

    // Withdrawal by pc_high, then re-request with the same cause.
    bus.src_req = 4'b0100;
    tick();
    bus.src_req = 4'b0000;
    tick();
    check_outs("t3_req", 1'b1, 1'b0, IRQ_SRC_UART_TX, 4'b0100);
    bus.pc_high = 1'b1;
    tick();
    check_outs("t3_withdraw", 1'b0, 1'b0, 2'd2, 4'b0100);
    tick();
    check_outs("t3_blocked", 1'b0, 1'b0, 2'd2, 4'b0100);
    bus.pc_high = 1'b0;
    tick();
    check_outs("t3_rereq", 1'b1, 1'b0, 2'd2, 4'b0100);
    // Ack has priority over pc_high.
    bus.pc_high = 1'b1;
    pulse_ack();
    bus.pc_high = 1'b0;
    check_outs("t3_ack_prio", 1'b0, 1'b1, 2'd2, 4'b0000);
    pulse_done();

    // Masked source pends but does not request.
    bus.irq_mask = 4'b1110;
    bus.src_req  = 4'b0001;
    tick();
    bus.src_req  = 4'b0000;
    tick();
    check_outs("t4_masked", 1'b0, 1'b0, 2'd2, 4'b0001);
    bus.irq_mask = 4'b1111;
    tick();
    check_outs("t4_unmask", 1'b1, 1'b0, 2'd0, 4'b0001);
    // Masking the cause during REQ does not withdraw.
    bus.irq_mask = 4'b1110;
    tick();
    check_outs("t4_mask_in_req", 1'b1, 1'b0, 2'd0, 4'b0001);
    // New rising request in the ack cycle: set beats clear.
    bus.src_req = 4'b0001;
    pulse_ack();
    bus.src_req = 4'b0000;
    check_outs("t4_set_wins", 1'b0, 1'b1, 2'd0, 4'b0001);
    pulse_done();
    check_outs("t4_idle_masked", 1'b0, 1'b0, 2'd0, 4'b0001);
    bus.irq_mask = 4'b1111;
    tick();
    check_outs("t4_req_again", 1'b1, 1'b0, 2'd0, 4'b0001);
    pulse_ack();

    // No nesting: new source in SERVICE only pends.
    bus.src_req = 4'b0100;
    tick();
    bus.src_req = 4'b0000;
    tick();
    check_outs("t5_nest", 1'b0, 1'b1, 2'd0, 4'b0100);
    // Asynchronous reset mid-SERVICE.
    #2;
    reset = 1'b1;
    #1;
    check_outs("t5_async_rst", 1'b0, 1'b0, 2'd0, 4'b0000);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_outs("t5_after_rst", 1'b0, 1'b0, 2'd0, 4'b0000);

    // Held timer level through ack and done.
    bus.src_req = 4'b0001;
    tick();
    tick();
    check_outs("t6_req", 1'b1, 1'b0, 2'd0, 4'b0001);
    pulse_ack();
`ifdef IRQ_EDGE_EN
    check_outs("t6_svc", 1'b0, 1'b1, 2'd0, 4'b0000);
`else
    check_outs("t6_svc", 1'b0, 1'b1, 2'd0, 4'b0001);
`endif
    pulse_done();
    tick();
`ifdef IRQ_EDGE_EN
    check_outs("t6_after_done", 1'b0, 1'b0, 2'd0, 4'b0000);
    tick();
    check_outs("t6_no_repend", 1'b0, 1'b0, 2'd0, 4'b0000);
`else
    check_outs("t6_after_done", 1'b1, 1'b0, 2'd0, 4'b0001);
`endif
    bus.src_req = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
